sync_timing_gen: RTL and testbench

- Parametrised successor to the fixed 720p hsync/vsync to FV/LV converter in the SDI-to-MIPI bridge pixel path.
- Converts pixel-clock hsync/vsync into frame-valid and line-valid for the CSI-2 packer.
- Adds configurable sync polarity, configurable window geometry and counter width, line/frame length measurement, and a lock qualifier that gates FV/LV.
- Flags timing errors.

---
 rtl/sync_timing_gen.sv | 194 +++++++++++++++++++
 tb/tb_sync_timing_gen.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_timing_gen.sv
// Pixel-clock hsync/vsync to frame-valid/line-valid converter with polarity control,
// line/frame length measurement, lock qualification and timing-error pulses.
module sync_timing_gen #(
   parameter int unsigned CNT_W       = 13,
   parameter int unsigned H_START     = 260,
   parameter int unsigned H_ACTIVE    = 1280,
   parameter int unsigned V_START     = 25,
   parameter int unsigned V_ACTIVE    = 720,
   parameter bit          HS_POL      = 1'b1,
   parameter bit          VS_POL      = 1'b1,
   parameter int unsigned LOCK_FRAMES = 2
) (
   input  logic             pix_clk,
   input  logic             rst,
   input  logic             vsync_i,
   input  logic             hsync_i,
   output logic             fv_o,
   output logic             lv_o,
   output logic             locked_o,
   output logic             frame_start_o,
   output logic [CNT_W-1:0] h_total_o,
   output logic [CNT_W-1:0] v_total_o,
   output logic             err_o
);

   typedef enum logic [1:0] {ST_UNLOCKED, ST_ACQUIRE, ST_LOCKED} state_t;

   localparam logic [CNT_W-1:0] C_MAX   = '1;
   localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] C_H_BEG = CNT_W'(H_START);
   localparam logic [CNT_W-1:0] C_H_END = CNT_W'(H_START + H_ACTIVE);
   localparam logic [CNT_W-1:0] C_V_BEG = CNT_W'(V_START);
   localparam logic [CNT_W-1:0] C_V_END = CNT_W'(V_START + V_ACTIVE);
   localparam logic [3:0]       C_LOCK  = 4'(LOCK_FRAMES);

   logic             r_hs_raw, r_vs_raw, r_hs_lvl, r_vs_lvl, r_hs_prev, r_vs_prev;
   logic             w_hs_edge, w_vs_edge;
   logic [CNT_W-1:0] r_h_cnt, r_v_cnt, r_h_total, r_v_total;
   logic [CNT_W-1:0] w_h_len, w_v_len;
   logic             r_h_armed, r_v_armed, r_h_valid, r_frame_bad;
   logic             w_h_sat, w_line_bad, w_geom_ok, w_frame_clean, w_v_match;
   state_t           r_state, w_state_nxt;
   logic [3:0]       r_good, w_good_nxt;
   logic             w_err, w_lock_nxt, w_fv_nxt, w_lv_nxt;
   logic             r_fv, r_lv, r_locked, r_fs, r_err;

   // Raw registers reset to the inactive level so no false edge follows reset.
   always_ff @(posedge pix_clk) begin
      if (rst) begin
         r_hs_raw  <= ~HS_POL;
         r_vs_raw  <= ~VS_POL;
         r_hs_lvl  <= 1'b0;
         r_vs_lvl  <= 1'b0;
         r_hs_prev <= 1'b0;
         r_vs_prev <= 1'b0;
      end else begin
         r_hs_raw  <= hsync_i;
         r_vs_raw  <= vsync_i;
         r_hs_lvl  <= ~(r_hs_raw ^ HS_POL);
         r_vs_lvl  <= ~(r_vs_raw ^ VS_POL);
         r_hs_prev <= r_hs_lvl;
         r_vs_prev <= r_vs_lvl;
      end
   end

   assign w_hs_edge = r_hs_lvl & ~r_hs_prev;
   assign w_vs_edge = r_vs_lvl & ~r_vs_prev;

   assign w_h_sat = (r_h_cnt == C_MAX);
   assign w_h_len = w_h_sat ? C_MAX : r_h_cnt + C_ONE;
   assign w_v_len = (r_v_cnt == C_MAX) ? C_MAX : r_v_cnt + C_ONE;

   always_ff @(posedge pix_clk) begin
      if (rst) begin
         r_h_cnt     <= '0;
         r_v_cnt     <= '0;
         r_h_total   <= '0;
         r_v_total   <= '0;
         r_h_armed   <= 1'b0;
         r_v_armed   <= 1'b0;
         r_h_valid   <= 1'b0;
         r_frame_bad <= 1'b0;
      end else begin
         if (w_hs_edge) begin
            r_h_cnt   <= '0;
            r_h_armed <= 1'b1;
            if (r_h_armed) begin
               r_h_total <= w_h_len;
               r_h_valid <= 1'b1;
            end
         end else if (!w_h_sat) begin
            r_h_cnt <= r_h_cnt + C_ONE;
         end

         if (w_vs_edge) begin
            r_v_cnt   <= '0;
            r_v_armed <= 1'b1;
            if (r_v_armed) r_v_total <= w_v_len;
         end else if (w_hs_edge && (r_v_cnt != C_MAX)) begin
            r_v_cnt <= r_v_cnt + C_ONE;
         end

         if (w_vs_edge)                   r_frame_bad <= 1'b0;
         else if (w_line_bad || w_h_sat)  r_frame_bad <= 1'b1;
      end
   end

   assign w_line_bad    = w_hs_edge && r_h_valid && (w_h_len != r_h_total);
   assign w_geom_ok     = (r_h_total >= C_H_END) && (w_v_len >= C_V_END);
   assign w_frame_clean = !r_frame_bad && !w_line_bad && w_geom_ok;
   assign w_v_match     = (w_v_len == r_v_total);

   always_ff @(posedge pix_clk) begin
      if (rst) begin
         r_state <= ST_UNLOCKED;
         r_good  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_good  <= w_good_nxt;
      end
   end

   // The arming frame has no previous line count, so it is qualified on
   // line consistency and geometry only and counts toward lock.
   always_comb begin
      w_state_nxt = r_state;
      w_good_nxt  = r_good;
      w_err       = 1'b0;
      case (r_state)
         ST_UNLOCKED: begin
            if (w_vs_edge && r_h_armed && r_v_armed) begin
               w_good_nxt  = w_frame_clean ? 4'd1 : 4'd0;
               w_state_nxt = (w_good_nxt >= C_LOCK) ? ST_LOCKED : ST_ACQUIRE;
            end
         end
         ST_ACQUIRE: begin
            if (w_vs_edge) begin
               if (w_frame_clean && w_v_match) begin
                  w_good_nxt = r_good + 4'd1;
                  if (w_good_nxt >= C_LOCK) w_state_nxt = ST_LOCKED;
               end else begin
                  w_good_nxt = '0;
                  w_err      = 1'b1;
               end
            end else if (w_line_bad) begin
               w_good_nxt = '0;
               w_err      = 1'b1;
            end
         end
         ST_LOCKED: begin
            if (w_line_bad || w_h_sat || (w_vs_edge && !(w_frame_clean && w_v_match))) begin
               w_state_nxt = ST_UNLOCKED;
               w_good_nxt  = '0;
               w_err       = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_UNLOCKED;
            w_good_nxt  = '0;
         end
      endcase
   end

   // Output windows are gated by the next state so an unlock blanks FV/LV
   // on the same edge that reports the error.
   assign w_lock_nxt = (w_state_nxt == ST_LOCKED);
   assign w_fv_nxt   = w_lock_nxt && !w_vs_edge && (r_v_cnt >= C_V_BEG) && (r_v_cnt < C_V_END);
   assign w_lv_nxt   = w_fv_nxt && !w_hs_edge && (r_h_cnt >= C_H_BEG) && (r_h_cnt < C_H_END);

   always_ff @(posedge pix_clk) begin
      if (rst) begin
         r_fv     <= 1'b0;
         r_lv     <= 1'b0;
         r_locked <= 1'b0;
         r_fs     <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_fv     <= w_fv_nxt;
         r_lv     <= w_lv_nxt;
         r_locked <= w_lock_nxt;
         r_fs     <= w_vs_edge;
         r_err    <= w_err;
      end
   end

   assign fv_o          = r_fv;
   assign lv_o          = r_lv;
   assign locked_o      = r_locked;
   assign frame_start_o = r_fs;
   assign err_o         = r_err;
   assign h_total_o     = r_h_total;
   assign v_total_o     = r_v_total;

endmodule

// File: tb/tb_sync_timing_gen.sv
// Bench for sync_timing_gen: small geometry (40x12 frames), one active-high and one
// active-low instance fed the same timing, checked per frame window against a table.
module tb_sync_timing_gen;

   localparam int unsigned CW = 8;

   typedef struct {
      int h_len;
      int short_line;
      int short_len;
      int rst_at;
      int exp_err;
      int exp_locked;
      int exp_lv_pul;
      int exp_lv_cyc;
      int exp_fv_cyc;
      int exp_htot;
      int exp_vtot;
   } frame_vec_t;

   logic clk, rst, hs, vs, hs_n, vs_n;
   logic [1:0] fv_w, lv_w, lk_w, fs_w, err_w;
   logic [1:0][CW-1:0] htot_w, vtot_w;

   int n_checks = 0;
   int n_errors = 0;
   int err_cnt[2], fs_cnt[2], fv_cyc[2], lv_cyc[2], lv_pul[2], lv_nofv[2];
   int b_err[2], b_fs[2], b_fv[2], b_lvc[2], b_lvp[2], b_nofv[2];
   logic lv_prev[2];
   frame_vec_t tbl[16];

   assign hs_n = ~hs;
   assign vs_n = ~vs;

   sync_timing_gen #(.CNT_W(CW), .H_START(10), .H_ACTIVE(20), .V_START(3), .V_ACTIVE(6),
                     .HS_POL(1'b1), .VS_POL(1'b1), .LOCK_FRAMES(2)) u_dut_p (
      .pix_clk(clk), .rst(rst), .vsync_i(vs), .hsync_i(hs),
      .fv_o(fv_w[0]), .lv_o(lv_w[0]), .locked_o(lk_w[0]), .frame_start_o(fs_w[0]),
      .h_total_o(htot_w[0]), .v_total_o(vtot_w[0]), .err_o(err_w[0]));

   sync_timing_gen #(.CNT_W(CW), .H_START(10), .H_ACTIVE(20), .V_START(3), .V_ACTIVE(6),
                     .HS_POL(1'b0), .VS_POL(1'b0), .LOCK_FRAMES(2)) u_dut_n (
      .pix_clk(clk), .rst(rst), .vsync_i(vs_n), .hsync_i(hs_n),
      .fv_o(fv_w[1]), .lv_o(lv_w[1]), .locked_o(lk_w[1]), .frame_start_o(fs_w[1]),
      .h_total_o(htot_w[1]), .v_total_o(vtot_w[1]), .err_o(err_w[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 2; i++) begin
         err_cnt[i] = 0; fs_cnt[i] = 0; fv_cyc[i] = 0;
         lv_cyc[i] = 0; lv_pul[i] = 0; lv_nofv[i] = 0; lv_prev[i] = 1'b0;
      end
   end

   always @(posedge clk) begin
      #2;
      for (int i = 0; i < 2; i++) begin
         if (err_w[i] === 1'b1) err_cnt[i]++;
         if (fs_w[i] === 1'b1) fs_cnt[i]++;
         if (fv_w[i] === 1'b1) fv_cyc[i]++;
         if (lv_w[i] === 1'b1) begin
            lv_cyc[i]++;
            if (fv_w[i] !== 1'b1) lv_nofv[i]++;
            if (!lv_prev[i]) lv_pul[i]++;
         end
         lv_prev[i] = (lv_w[i] === 1'b1);
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic snap();
      for (int i = 0; i < 2; i++) begin
         b_err[i] = err_cnt[i]; b_fs[i] = fs_cnt[i]; b_fv[i] = fv_cyc[i];
         b_lvc[i] = lv_cyc[i];  b_lvp[i] = lv_pul[i]; b_nofv[i] = lv_nofv[i];
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         hs = 1'b0; vs = 1'b0; rst = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; hs = 1'b0; vs = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic check_cleared(input string tag);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s dut%0d fv", tag, i), int'(fv_w[i]), 0);
         check($sformatf("%s dut%0d lv", tag, i), int'(lv_w[i]), 0);
         check($sformatf("%s dut%0d locked", tag, i), int'(lk_w[i]), 0);
         check($sformatf("%s dut%0d err", tag, i), int'(err_w[i]), 0);
         check($sformatf("%s dut%0d fs", tag, i), int'(fs_w[i]), 0);
         check($sformatf("%s dut%0d h_total", tag, i), int'(htot_w[i]), 0);
         check($sformatf("%s dut%0d v_total", tag, i), int'(vtot_w[i]), 0);
      end
   endtask

   // 12 lines per frame, hsync active 4 cycles, vsync active lines 0-1.
   task automatic drive_frame(input frame_vec_t v);
      int len;
      int fcyc;
      fcyc = 0;
      for (int ln = 0; ln < 12; ln++) begin
         len = (ln == v.short_line) ? v.short_len : v.h_len;
         for (int c = 0; c < len; c++) begin
            @(negedge clk);
            hs  = (c < 4);
            vs  = (ln < 2);
            rst = (fcyc == v.rst_at);
            fcyc++;
         end
      end
   endtask

   task automatic run_rows(input int r0, input int r1);
      for (int r = r0; r < r1; r++) begin
         snap();
         drive_frame(tbl[r]);
         for (int i = 0; i < 2; i++) begin
            check($sformatf("row%0d dut%0d err", r, i), err_cnt[i] - b_err[i], tbl[r].exp_err);
            check($sformatf("row%0d dut%0d fs", r, i), fs_cnt[i] - b_fs[i], 1);
            check($sformatf("row%0d dut%0d locked", r, i), int'(lk_w[i]), tbl[r].exp_locked);
            check($sformatf("row%0d dut%0d lv_pulses", r, i), lv_pul[i] - b_lvp[i], tbl[r].exp_lv_pul);
            check($sformatf("row%0d dut%0d lv_cycles", r, i), lv_cyc[i] - b_lvc[i], tbl[r].exp_lv_cyc);
            check($sformatf("row%0d dut%0d fv_cycles", r, i), fv_cyc[i] - b_fv[i], tbl[r].exp_fv_cyc);
            check($sformatf("row%0d dut%0d lv_without_fv", r, i), lv_nofv[i] - b_nofv[i], 0);
            check($sformatf("row%0d dut%0d h_total", r, i), int'(htot_w[i]), tbl[r].exp_htot);
            check($sformatf("row%0d dut%0d v_total", r, i), int'(vtot_w[i]), tbl[r].exp_vtot);
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //            hlen shl  slen rst  err lk lvp lvc  fvc  ht  vt
      tbl[0]  = '{40,  -1,  0,   -1,  0,  0, 0,  0,   0,   40, 0};
      tbl[1]  = '{40,  -1,  0,   -1,  0,  0, 0,  0,   0,   40, 12};
      tbl[2]  = '{40,  -1,  0,   -1,  0,  1, 6,  120, 240, 40, 12};
      tbl[3]  = '{40,  -1,  0,   -1,  0,  1, 6,  120, 240, 40, 12};
      tbl[4]  = '{40,  5,   39,  -1,  1,  0, 3,  60,  118, 40, 12};
      tbl[5]  = '{40,  -1,  0,   -1,  0,  0, 0,  0,   0,   40, 12};
      tbl[6]  = '{40,  -1,  0,   -1,  0,  0, 0,  0,   0,   40, 12};
      tbl[7]  = '{40,  -1,  0,   -1,  0,  1, 6,  120, 240, 40, 12};
      tbl[8]  = '{40,  -1,  0,   180, 0,  0, 2,  27,  57,  40, 0};
      tbl[9]  = '{40,  -1,  0,   -1,  0,  0, 0,  0,   0,   40, 0};
      tbl[10] = '{40,  -1,  0,   -1,  0,  0, 0,  0,   0,   40, 12};
      tbl[11] = '{40,  -1,  0,   -1,  0,  1, 6,  120, 240, 40, 12};
      tbl[12] = '{25,  -1,  0,   -1,  0,  0, 0,  0,   0,   25, 0};
      tbl[13] = '{25,  -1,  0,   -1,  0,  0, 0,  0,   0,   25, 12};
      tbl[14] = '{25,  -1,  0,   -1,  1,  0, 0,  0,   0,   25, 12};
      tbl[15] = '{25,  -1,  0,   -1,  1,  0, 0,  0,   0,   25, 12};

      rst = 1'b1; hs = 1'b0; vs = 1'b0;
      do_reset();
      check_cleared("reset");

      // lock, short-line unlock and relock, mid-line reset and re-arm
      run_rows(0, 12);

      // sync lost while locked: lock holds until the line counter saturates
      snap();
      idle(200);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("lost dut%0d locked_before_sat", i), int'(lk_w[i]), 1);
         check($sformatf("lost dut%0d err_before_sat", i), err_cnt[i] - b_err[i], 0);
      end
      idle(100);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("lost dut%0d err_after_sat", i), err_cnt[i] - b_err[i], 1);
         check($sformatf("lost dut%0d locked_after_sat", i), int'(lk_w[i]), 0);
         check($sformatf("lost dut%0d fv_after_sat", i), int'(fv_w[i]), 0);
      end

      do_reset();
      check_cleared("reset2");

      // line shorter than the active window never locks
      run_rows(12, 16);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
